// File: rtl/reorder_buffer_occupancy_tracker_pkg.sv
// Shared sizing for the reorder buffer occupancy tracker: default depth, ways and derived widths.
package reorder_buffer_occupancy_tracker_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_WAYS  = 2;
    localparam int unsigned ROB_PW    = $clog2(ROB_DEPTH);
    localparam int unsigned ROB_CNTW  = $clog2(ROB_DEPTH + 1);
    localparam int unsigned ROB_RW    = $clog2(ROB_WAYS + 1);

    // ROB tag width now tracks the pointer width directly.
    localparam int unsigned ROB_TAG_W = ROB_PW;

endpackage

// File: rtl/reorder_buffer_ptr_wrap.sv
// Modulo-DEPTH pointer advance, valid for any depth including non-powers of two.
module reorder_buffer_ptr_wrap
    import reorder_buffer_occupancy_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned INCW  = ROB_RW,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [PW-1:0]   i_ptr,
    input  logic [INCW-1:0] i_inc,
    output logic [PW-1:0]   o_nxt_ptr_c
);

    logic [PW:0] w_sum;

    // ptr + inc never reaches 2*DEPTH, so one conditional subtract is enough.
    always_comb begin
        w_sum = (PW+1)'(i_ptr) + (PW+1)'(i_inc);
        if (w_sum >= (PW+1)'(DEPTH)) begin
            o_nxt_ptr_c = PW'(w_sum - (PW+1)'(DEPTH));
        end else begin
            o_nxt_ptr_c = PW'(w_sum);
        end
    end

endmodule

// File: rtl/reorder_buffer_occupancy_tracker.sv
// Head/tail/count manager for the reorder buffer: multi-way allocate and retire,
// flush, occupancy flags and sticky overflow/underflow errors.
module reorder_buffer_occupancy_tracker
    import reorder_buffer_occupancy_tracker_pkg::*;
#(
    parameter int unsigned DEPTH     = ROB_DEPTH,
    parameter int unsigned WAYS      = ROB_WAYS,
    parameter int unsigned AF_THRESH = DEPTH - WAYS,
    localparam int unsigned PW       = $clog2(DEPTH),
    localparam int unsigned CNTW     = $clog2(DEPTH + 1),
    localparam int unsigned RW       = $clog2(WAYS + 1)
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic [RW-1:0]   alloc_cnt_in,
    input  logic [RW-1:0]   retire_cnt_in,
    input  logic            flush_in,
    output logic            alloc_ok_out,
    output logic [PW-1:0]   tail_ptr_out,
    output logic [PW-1:0]   head_ptr_out,
    output logic [CNTW-1:0] count_out,
    output logic [CNTW-1:0] free_out,
    output logic            full_out,
    output logic            empty_out,
    output logic            almost_full_out,
    output logic            overflow_err_out,
    output logic            underflow_err_out
);

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] r_free;
    logic            r_full;
    logic            r_empty;
    logic            r_af;
    logic            r_ovf;
    logic            r_unf;

    logic            w_retire_ok;
    logic [RW-1:0]   w_a;
    logic [RW-1:0]   w_r;
    logic [CNTW-1:0] w_cnt_nxt;
    logic [PW-1:0]   w_head_nxt;
    logic [PW-1:0]   w_tail_nxt;

    // Accept checks look only at the registered count/free: no same-cycle bypass.
    always_comb begin
        alloc_ok_out = (CNTW'(alloc_cnt_in) <= r_free) && (alloc_cnt_in <= RW'(WAYS));
        w_retire_ok  = (CNTW'(retire_cnt_in) <= r_count) && (retire_cnt_in <= RW'(WAYS));
        w_a          = alloc_ok_out ? alloc_cnt_in : '0;
        w_r          = w_retire_ok ? retire_cnt_in : '0;
        w_cnt_nxt    = r_count + CNTW'(w_a) - CNTW'(w_r);
    end

    reorder_buffer_ptr_wrap #(.DEPTH(DEPTH), .INCW(RW)) u_tail_wrap (
        .i_ptr       (r_tail),
        .i_inc       (w_a),
        .o_nxt_ptr_c (w_tail_nxt)
    );

    reorder_buffer_ptr_wrap #(.DEPTH(DEPTH), .INCW(RW)) u_head_wrap (
        .i_ptr       (r_head),
        .i_inc       (w_r),
        .o_nxt_ptr_c (w_head_nxt)
    );

    // Reset beats flush beats normal update; flush keeps the sticky errors.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_free  <= CNTW'(DEPTH);
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_free  <= CNTW'(DEPTH);
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_cnt_nxt;
            r_free  <= CNTW'(DEPTH) - w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNTW'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= CNTW'(AF_THRESH));
            if ((alloc_cnt_in != '0) && !alloc_ok_out) begin
                r_ovf <= 1'b1;
            end
            if ((retire_cnt_in != '0) && !w_retire_ok) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign tail_ptr_out      = r_tail;
    assign head_ptr_out      = r_head;
    assign count_out         = r_count;
    assign free_out          = r_free;
    assign full_out          = r_full;
    assign empty_out         = r_empty;
    assign almost_full_out   = r_af;
    assign overflow_err_out  = r_ovf;
    assign underflow_err_out = r_unf;

endmodule

// File: tb/tb_reorder_buffer_occupancy_tracker.sv
// Directed self-checking bench: DEPTH=16/WAYS=2 main instance plus a DEPTH=12 wrap instance.
module tb_reorder_buffer_occupancy_tracker;

    logic clk;
    logic rst_n;

    logic [1:0] a_alloc, a_retire;
    logic       a_flush;
    logic       a_ok, a_full, a_empty, a_af, a_ovf, a_unf;
    logic [3:0] a_tail, a_head;
    logic [4:0] a_count, a_free;

    logic [1:0] b_alloc, b_retire;
    logic       b_flush;
    logic       b_ok, b_full, b_empty, b_af, b_ovf, b_unf;
    logic [3:0] b_tail, b_head;
    logic [3:0] b_count, b_free;

    int n_vec;
    int n_err;

    reorder_buffer_occupancy_tracker #(.DEPTH(16), .WAYS(2)) u_dut_a (
        .clk_in            (clk),
        .reset_n_in        (rst_n),
        .alloc_cnt_in      (a_alloc),
        .retire_cnt_in     (a_retire),
        .flush_in          (a_flush),
        .alloc_ok_out      (a_ok),
        .tail_ptr_out      (a_tail),
        .head_ptr_out      (a_head),
        .count_out         (a_count),
        .free_out          (a_free),
        .full_out          (a_full),
        .empty_out         (a_empty),
        .almost_full_out   (a_af),
        .overflow_err_out  (a_ovf),
        .underflow_err_out (a_unf)
    );

    reorder_buffer_occupancy_tracker #(.DEPTH(12), .WAYS(2)) u_dut_b (
        .clk_in            (clk),
        .reset_n_in        (rst_n),
        .alloc_cnt_in      (b_alloc),
        .retire_cnt_in     (b_retire),
        .flush_in          (b_flush),
        .alloc_ok_out      (b_ok),
        .tail_ptr_out      (b_tail),
        .head_ptr_out      (b_head),
        .count_out         (b_count),
        .free_out          (b_free),
        .full_out          (b_full),
        .empty_out         (b_empty),
        .almost_full_out   (b_af),
        .overflow_err_out  (b_ovf),
        .underflow_err_out (b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_count"}, 32'(a_count), 32'd0);
        chk({tag, "_free"},  32'(a_free),  32'd16);
        chk({tag, "_head"},  32'(a_head),  32'd0);
        chk({tag, "_tail"},  32'(a_tail),  32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_full"},  32'(a_full),  32'd0);
        chk({tag, "_af"},    32'(a_af),    32'd0);
        chk({tag, "_ovf"},   32'(a_ovf),   32'd0);
        chk({tag, "_unf"},   32'(a_unf),   32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_alloc = 2'd0; a_retire = 2'd0; a_flush = 1'b0;
        b_alloc = 2'd0; b_retire = 2'd0; b_flush = 1'b0;
        #2;

        // Reset state
        tick();
        chk_a_reset("reset");
        rst_n = 1'b1;

        // Fill 2 per cycle to full
        for (int i = 0; i < 8; i++) begin
            a_alloc = 2'd2;
            #1;
            chk("fill_tail", 32'(a_tail), 32'(2 * i));
            chk("fill_ok",   32'(a_ok),   32'd1);
            tick();
            chk("fill_count", 32'(a_count), 32'(2 * (i + 1)));
            chk("fill_full",  32'(a_full),  32'((i == 7) ? 1 : 0));
            chk("fill_af",    32'(a_af),    32'((2 * (i + 1) >= 14) ? 1 : 0));
        end
        a_alloc = 2'd0;
        #1;
        chk("fill_tail_wrap", 32'(a_tail), 32'd0);
        chk("fill_free",      32'(a_free), 32'd0);

        // Overflow refusal at full
        a_alloc = 2'd1;
        #1;
        chk("ovf_ok", 32'(a_ok), 32'd0);
        tick();
        chk("ovf_count", 32'(a_count), 32'd16);
        chk("ovf_flag",  32'(a_ovf),   32'd1);
        a_alloc = 2'd0;
        tick();
        chk("ovf_sticky", 32'(a_ovf), 32'd1);

        // Retire down to 10
        for (int i = 0; i < 3; i++) begin
            a_retire = 2'd2;
            tick();
        end
        a_retire = 2'd0;
        chk("ret_count", 32'(a_count), 32'd10);
        chk("ret_head",  32'(a_head),  32'd6);
        chk("ret_full",  32'(a_full),  32'd0);

        // Simultaneous alloc 2 / retire 1 at count 10
        a_alloc = 2'd2; a_retire = 2'd1;
        tick();
        a_alloc = 2'd0; a_retire = 2'd0;
        chk("sim_count", 32'(a_count), 32'd11);
        chk("sim_head",  32'(a_head),  32'd7);
        chk("sim_tail",  32'(a_tail),  32'd2);
        chk("sim_free",  32'(a_free),  32'd5);

        // Drain to 1, head wraps 7 -> 1
        for (int i = 0; i < 5; i++) begin
            a_retire = 2'd2;
            tick();
        end
        chk("drain_count", 32'(a_count), 32'd1);
        chk("drain_head",  32'(a_head),  32'd1);
        chk("drain_unf",   32'(a_unf),   32'd0);

        // Underflow refusal
        a_retire = 2'd2;
        tick();
        a_retire = 2'd0;
        chk("unf_count", 32'(a_count), 32'd1);
        chk("unf_head",  32'(a_head),  32'd1);
        chk("unf_flag",  32'(a_unf),   32'd1);
        chk("unf_empty", 32'(a_empty), 32'd0);

        // Grow to 7
        for (int i = 0; i < 3; i++) begin
            a_alloc = 2'd2;
            tick();
        end
        a_alloc = 2'd0;
        chk("grow_count", 32'(a_count), 32'd7);
        chk("grow_tail",  32'(a_tail),  32'd8);

        // Flush with alloc/retire: inputs ignored, errors kept
        a_flush = 1'b1; a_alloc = 2'd2; a_retire = 2'd1;
        tick();
        a_flush = 1'b0; a_alloc = 2'd0; a_retire = 2'd0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_head",  32'(a_head),  32'd0);
        chk("flush_tail",  32'(a_tail),  32'd0);
        chk("flush_empty", 32'(a_empty), 32'd1);
        chk("flush_free",  32'(a_free),  32'd16);
        chk("flush_ovf",   32'(a_ovf),   32'd1);
        chk("flush_unf",   32'(a_unf),   32'd1);

        // Reset with flush and alloc: reset wins, errors cleared
        a_alloc = 2'd1;
        tick();
        rst_n = 1'b0; a_flush = 1'b1; a_alloc = 2'd2;
        tick();
        rst_n = 1'b1; a_flush = 1'b0; a_alloc = 2'd0;
        chk_a_reset("rst_prio");

        // DEPTH=12: bring tail and head to 11, then wrap both by 2
        for (int i = 0; i < 5; i++) begin
            b_alloc = 2'd2;
            tick();
        end
        b_alloc = 2'd1;
        tick();
        b_alloc = 2'd0;
        chk("np2_tail11", 32'(b_tail),  32'd11);
        chk("np2_cnt11",  32'(b_count), 32'd11);
        for (int i = 0; i < 5; i++) begin
            b_retire = 2'd2;
            tick();
        end
        b_retire = 2'd1;
        tick();
        b_retire = 2'd0;
        chk("np2_head11", 32'(b_head),  32'd11);
        chk("np2_cnt0",   32'(b_count), 32'd0);
        b_alloc = 2'd2;
        #1;
        chk("np2_tag_base", 32'(b_tail), 32'd11);
        tick();
        b_alloc = 2'd0;
        chk("np2_tail_wrap", 32'(b_tail),  32'd1);
        chk("np2_cnt2",      32'(b_count), 32'd2);
        chk("np2_free",      32'(b_free),  32'd10);
        b_retire = 2'd2;
        tick();
        b_retire = 2'd0;
        chk("np2_head_wrap", 32'(b_head),  32'd1);
        chk("np2_empty",     32'(b_empty), 32'd1);
        chk("np2_errs",      32'({b_ovf, b_unf}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
